// File: rtl/boron_pkg.sv
// boron_pkg: shared BORON key-schedule constants, S-box and FSM encoding
package boron_pkg;
  localparam int KEY_W = 80;
  localparam int ROUNDS = 25;
  localparam int ROT = 13;
  // nibble i of SBOX is SBOX(i)
  localparam logic [63:0] SBOX = 64'h6358_F02D_AC97_1B4E;
  typedef enum logic {IDLE, GEN} state_t;
endpackage

// File: rtl/boron_key_update.sv
// boron_key_update: one combinational BORON key-schedule step
import boron_pkg::*;
module boron_key_update (
  input  logic [KEY_W-1:0] kin,
  input  logic [4:0]       rc,
  output logic [KEY_W-1:0] kout
);
  logic [KEY_W-1:0] r;
  assign r = {kin[KEY_W-ROT-1:0], kin[KEY_W-1:KEY_W-ROT]};
  assign kout = {r[79:64], r[63:59] ^ rc, r[58:4], SBOX[{r[3:0], 2'b00} +: 4]};
endmodule

// File: rtl/key_schedule_gen.sv
// key_schedule_gen: expands an 80-bit master key into the 26-slice BORON round-key bank
import boron_pkg::*;
module key_schedule_gen (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            masterKey,
  input  logic                        genStart,
  output logic [KEY_W*(ROUNDS+1)-1:0] key_register,
  output logic                        keyReady,
  output logic                        busy
);
  state_t state, state_n;
  logic [4:0] cnt;
  logic [KEY_W-1:0] kstate, knext;
  boron_key_update u_upd (.kin(kstate), .rc(cnt), .kout(knext));
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (genStart ? GEN : IDLE) : (cnt == 5'(ROUNDS) ? IDLE : GEN);
  end
  always_ff @(negedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(negedge clk) begin
    if (!reset) begin
      key_register <= '0;
      kstate <= '0;
      cnt <= '0;
      keyReady <= 1'b0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (genStart) begin
        key_register[KEY_W-1:0] <= masterKey;
        kstate <= masterKey;
        cnt <= 5'd1;
        keyReady <= 1'b0;
        busy <= 1'b1;
      end
    end else begin
      key_register[cnt*KEY_W +: KEY_W] <= knext;
      kstate <= knext;
      cnt <= cnt + 5'd1;
      if (cnt == 5'(ROUNDS)) begin
        keyReady <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_key_schedule_gen.sv
// tb_key_schedule_gen: directed and randomized checks of the BORON key bank against a reference model
module tb_key_schedule_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic genStart = 1'b0;
  logic [79:0] masterKey = '0;
  logic [2079:0] key_register;
  logic keyReady, busy;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [3:0] SB [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                     4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  always #5 clk = ~clk;
  key_schedule_gen dut (
    .clk(clk), .reset(reset), .masterKey(masterKey), .genStart(genStart),
    .key_register(key_register), .keyReady(keyReady), .busy(busy)
  );
  function automatic logic [79:0] upd(input logic [79:0] k, input int i);
    logic [79:0] r;
    r = (k << 13) | (k >> 67);
    r[3:0] = SB[r[3:0]];
    r[63:59] = r[63:59] ^ 5'(i);
    return r;
  endfunction
  function automatic logic [2079:0] bank(input logic [79:0] mk);
    logic [79:0] k;
    logic [2079:0] b;
    k = mk;
    b = '0;
    for (int i = 0; i < 26; i++) begin
      if (i > 0) k = upd(k, i);
      b[80*i +: 80] = k;
    end
    return b;
  endfunction
  function automatic logic [79:0] rnd80();
    return 80'({$urandom, $urandom, $urandom});
  endfunction
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask
  task automatic check_cleared(input string tag);
    for (int i = 0; i < 26; i++) check($sformatf("%s slice%0d", tag, i), key_register[80*i +: 80], 80'h0);
    check({tag, " keyReady"}, 80'(keyReady), 80'h0);
    check({tag, " busy"}, 80'(busy), 80'h0);
  endtask
  task automatic gen_run(input logic [79:0] mk, input int pulse_at, input int reset_at, input bit hold);
    logic [2079:0] e;
    e = bank(mk);
    masterKey = mk;
    genStart = 1'b1;
    tick();
    genStart = hold;
    check("start slice0", key_register[79:0], mk);
    check("start busy", 80'(busy), 80'h1);
    check("start keyReady", 80'(keyReady), 80'h0);
    for (int k = 1; k <= 25; k++) begin
      masterKey = rnd80();
      if (k == pulse_at) genStart = 1'b1;
      if (k == reset_at) reset = 1'b0;
      tick();
      if (!hold) genStart = 1'b0;
      if (k == reset_at) begin
        reset = 1'b1;
        check_cleared("midreset");
        return;
      end
      check($sformatf("edge%0d slice", k), key_register[80*k +: 80], e[80*k +: 80]);
      check($sformatf("edge%0d busy", k), 80'(busy), 80'(k < 25));
      check($sformatf("edge%0d keyReady", k), 80'(keyReady), 80'(k == 25));
    end
    for (int i = 0; i < 26; i++) check($sformatf("bank slice%0d", i), key_register[80*i +: 80], e[80*i +: 80]);
  endtask
  initial begin
    logic [79:0] k2;
    logic [2079:0] e2;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_cleared("reset");
    gen_run(80'h0, 0, 0, 1'b0);
    check("zero slice1", key_register[159:80], 80'h0000_0800_0000_0000_000E);
    tick();
    check("idle hold keyReady", 80'(keyReady), 80'h1);
    gen_run({80{1'b1}}, 0, 0, 1'b0);
    check("ones slice1", key_register[159:80], 80'hFFFF_F7FF_FFFF_FFFF_FFF6);
    gen_run({80{1'b1}}, 10, 0, 1'b0);
    gen_run(rnd80(), 0, 12, 1'b0);
    tick();
    check("post-reset idle busy", 80'(busy), 80'h0);
    gen_run(rnd80(), 0, 0, 1'b0);
    gen_run(rnd80(), 0, 0, 1'b1);
    k2 = rnd80();
    e2 = bank(k2);
    masterKey = k2;
    tick();
    genStart = 1'b0;
    check("restart keyReady", 80'(keyReady), 80'h0);
    check("restart busy", 80'(busy), 80'h1);
    check("restart slice0", key_register[79:0], k2);
    for (int k = 1; k <= 25; k++) tick();
    check("restart done keyReady", 80'(keyReady), 80'h1);
    check("restart slice25", key_register[2079:2000], e2[2079:2000]);
    check("restart slice13", key_register[80*13 +: 80], e2[80*13 +: 80]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
